dot_prod_acc: RTL
=================

# dot_prod_acc

Downstream accumulation stage for the 16-bit sequential multiplier. It consumes the signed 32-bit product and the one-cycle `done` pulse, and sums a programmed number of products into a wide signed accumulator. It then presents the dot-product result on a valid/ready output and raises `busy` so the issuing controller stops starting multiplies while a result is still unconsumed.

## Interface
- `ACC_W`, 40, accumulator/result width in bits; legal range 33..64.
- `LEN_W`, 8, width of the vector-length field; max vector length 2^LEN_W−1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_vec`  in  1  begin a new vector; sampled only in IDLE.
- `vec_len`  in  LEN_W  number of products in the vector; sampled with `start_vec`.
- `p_in`  in  32  signed two's-complement product (multiplier `p_out`).
- `p_valid`  in  1  one-cycle product strobe (multiplier `done`).
- `acc_out`  out  ACC_W  signed dot-product result; stable while `acc_valid`=1.
- `acc_valid`  out  1  result available.
- `acc_ready`  in  1  consumer accepts result.
- `busy`  out  1  high in ACCUM and HOLD.
- `term_cnt`  out  LEN_W  products accumulated in the current vector.
- `ovf`  out  1  sticky per vector: at least one accumulate overflowed ACC_W signed range.
- `lost`  out  1  sticky until reset: a `p_valid` arrived in IDLE or HOLD and was dropped.

## Operation
- States: IDLE, ACCUM, HOLD; 2-bit encoding; unused code returns to IDLE.
- IDLE, `start_vec`=1, `vec_len`≠0:
  - acc←0, `term_cnt`←0, `ovf`←0, remaining←`vec_len`.
  - Next state is ACCUM.
- IDLE, `start_vec`=1, `vec_len`=0:
  - acc←0, `ovf`←0, `term_cnt`←0.
  - Next state is HOLD, so an empty vector yields result 0.
- ACCUM, `p_valid`=1:
  - acc←acc+sign_extend(`p_in`, ACC_W); `term_cnt`+1; remaining−1.
  - If remaining was 1, next state is HOLD.
- ACCUM, `p_valid`=0: hold all registers.
- HOLD:
  - `acc_valid`=1 and `acc_out`=acc.
  - On `acc_ready`=1, go to IDLE. `acc_out` keeps its last value; `term_cnt` and `ovf` keep their values until the next `start_vec`.
- `start_vec` outside IDLE is ignored, including in the same cycle as the HOLD handshake.
- `p_valid` in IDLE or HOLD does not change acc; it sets `lost`.
- Overflow detection: operands have the same sign and the sum sign differs.
- Reset mid-vector discards the partial sum with no output.

## Timing
- Values after reset: state IDLE, `acc_out`=0, `acc_valid`=0, `busy`=0, `term_cnt`=0, `ovf`=0, `lost`=0.
- `acc_valid` rises in the cycle after the final `p_valid` edge (latency 1).
- For `vec_len`=0, `acc_valid` rises in the cycle after `start_vec`.
- `busy` rises in the cycle after an accepted `start_vec`. It falls in the cycle after the `acc_valid`&`acc_ready` handshake.
- Back-to-back `p_valid` on consecutive cycles is accepted; no minimum spacing.
- The result is held indefinitely under back-pressure; there is no timeout.

## Configuration
- `DOT_PROD_ACC_SAT_EN` defined: on overflow, acc clamps to +(2^(ACC_W−1)−1) or −2^(ACC_W−1) according to operand sign, and `ovf` is set.
- `DOT_PROD_ACC_SAT_EN` undefined: acc wraps modulo 2^ACC_W, and `ovf` is still set.

## Structure
- Shared package `mult_pkg` holds:
  - `PROD_W`=32 and `OPER_W`=16.
  - State localparams `ACC_IDLE`/`ACC_ACCUM`/`ACC_HOLD`.
- One combinational sub-module, `sat_add`: ACC_W signed adder with overflow flag and the optional clamp. It is controlled by the same macro.

## Test plan
- Vector `vec_len`=3, products 6, −4, 10 → `acc_out`=12, `acc_valid` one cycle after the 3rd strobe, `term_cnt`=3, `ovf`=0.
- Back-pressure: hold `acc_ready`=0 for 20 cycles → `acc_out` stable and `busy`=1. Then assert `acc_ready` → `acc_valid`=0 and `busy`=0 the next cycle.
- ACC_W=33, `vec_len`=4, four `p_in`=0x4000_0000:
  - With macro: `acc_out`=0x0_FFFF_FFFF, `ovf`=1.
  - Without macro: `acc_out`=0x1_0000_0000, `ovf`=1.
- `vec_len`=0 → `acc_out`=0 and `acc_valid`=1 one cycle after `start_vec`. A `p_valid` during HOLD → `lost`=1 and `acc_out` unchanged.
- Reset mid-vector after 2 of 5 products → all outputs at reset values. A new vector with products −32768×−32768 (0x4000_0000) and −1 → `acc_out`=0x3FFF_FFFF.
- `start_vec` pulsed in ACCUM and in the HOLD handshake cycle → ignored: `term_cnt` is not reset and the state goes to IDLE only.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: widths shared by the multiplier and accumulator, plus accumulator state codes.
package mult_pkg;
    localparam int PROD_W = 32;
    localparam int OPER_W = 16;
    localparam logic [1:0] ACC_IDLE  = 2'd0;
    localparam logic [1:0] ACC_ACCUM = 2'd1;
    localparam logic [1:0] ACC_HOLD  = 2'd2;
endpackage

// File: rtl/dot_prod_acc_sat_add.sv
// sat_add: W-bit signed adder with overflow flag.
// DOT_PROD_ACC_SAT_EN clamps the sum on overflow; otherwise the sum wraps.
module sat_add #(
    parameter int W = 40
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);
    logic [W-1:0] raw;
    assign raw   = a_i + b_i;
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
`ifdef DOT_PROD_ACC_SAT_EN
    assign sum_o = ovf_o ? (a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
`else
    assign sum_o = raw;
`endif
endmodule

// File: rtl/dot_prod_acc.sv
// dot_prod_acc: sums a programmed number of signed products and presents the result on valid/ready.
// DOT_PROD_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module dot_prod_acc
    import mult_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_vec,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [31:0]      p_in,
    input  logic             p_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic [LEN_W-1:0] term_cnt,
    output logic             ovf,
    output logic             lost
);
    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
    logic             ovf_q, ovf_d, lost_q, lost_d;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    sat_add #(.W(ACC_W)) u_add (
        .a_i  (acc_q),
        .b_i  ({{(ACC_W-PROD_W){p_in[PROD_W-1]}}, p_in}),
        .sum_o(sum),
        .ovf_o(sum_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        lost_d  = lost_q | (p_valid && state_q != ACC_ACCUM);
        case (state_q)
            ACC_IDLE: if (start_vec) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                rem_d   = vec_len;
                state_d = (vec_len == '0) ? ACC_HOLD : ACC_ACCUM;
            end
            ACC_ACCUM: if (p_valid) begin
                acc_d   = sum;
                ovf_d   = ovf_q | sum_ovf;
                cnt_d   = cnt_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == LEN_W'(1)) ? ACC_HOLD : ACC_ACCUM;
            end
            ACC_HOLD: state_d = acc_ready ? ACC_IDLE : ACC_HOLD;
            default:  state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = state_q == ACC_HOLD;
    assign busy      = state_q == ACC_ACCUM || state_q == ACC_HOLD;
    assign term_cnt  = cnt_q;
    assign ovf       = ovf_q;
    assign lost      = lost_q;
endmodule
